// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//
// Receive-side decoder for a single TMDS channel. Raw 10-bit words from a
// free-running 10:1 deserializer carry no symbol framing, so the block slides
// a 10-bit window across two consecutive words. It hunts for a run of control
// tokens at each bit offset. Once the run is found it holds that offset and
// decodes every symbol back into a video byte or a control code.
//
// Ports:
//   pixel_clk     in   1  pixel clock; all logic on its rising edge
//   rst           in   1  synchronous, active-low reset
//   raw_in        in  10  deserializer word, bit 0 earliest on the wire
//   data_out      out  8  decoded video byte (held across control tokens)
//   ctrl_out      out  2  {C1,C0} of the most recent control token
//   de            out  1  data enable, high for decoded data while locked
//   locked        out  1  symbol alignment achieved
//   bit_offset    out  4  current window offset, 0..9
//   realign_count out  8  number of lock losses, saturating at 255

module tmds_channel_decoder #(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_DWELL = 2048,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic [7:0] realign_count
);

    // dwell_cnt can step one past SEARCH_DWELL-1 on a lock-wins cycle, so it
    // is sized for SEARCH_DWELL itself. gap_cnt never exceeds LOCK_TIMEOUT-1.
    localparam int RUN_W   = (CTRL_RUN < 1)     ? 1 : $clog2(CTRL_RUN + 1);
    localparam int DWELL_W = (SEARCH_DWELL < 1) ? 1 : $clog2(SEARCH_DWELL + 1);
    localparam int GAP_W   = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [9:0]         raw_q;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [3:0]         bit_offset_q, bit_offset_d;
    logic [7:0]         realign_count_q, realign_count_d;
    logic [7:0]         data_out_q, data_out_d;
    logic [1:0]         ctrl_out_q, ctrl_out_d;
    logic               de_q, de_d;

    logic [18:0] cat;
    logic [9:0]  win;
    logic        is_token;
    logic [1:0]  token_code;
    logic [7:0]  q_word;
    logic [7:0]  dec_data;
    logic [3:0]  offset_next;

    // The top bit of the newer word can never land inside a window of offset
    // 0..9, so the concatenation only carries 19 bits.
    always_comb begin
        cat = {raw_in[8:0], raw_q};
        case (bit_offset_q)
            4'd0:    win = cat[9:0];
            4'd1:    win = cat[10:1];
            4'd2:    win = cat[11:2];
            4'd3:    win = cat[12:3];
            4'd4:    win = cat[13:4];
            4'd5:    win = cat[14:5];
            4'd6:    win = cat[15:6];
            4'd7:    win = cat[16:7];
            4'd8:    win = cat[17:8];
            4'd9:    win = cat[18:9];
            default: win = cat[9:0];
        endcase
    end

    // Classify the window as one of the four control tokens.
    always_comb begin
        is_token   = 1'b1;
        token_code = 2'b00;
        case (win)
            10'b1101010100: token_code = 2'b00;
            10'b0010101011: token_code = 2'b01;
            10'b0101010100: token_code = 2'b10;
            10'b1010101011: token_code = 2'b11;
            default:        is_token   = 1'b0;
        endcase
    end

    // Undo the transmitter's optional inversion (bit 9), then its XOR/XNOR
    // chaining (bit 8 selects XOR).
    always_comb begin
        q_word      = win[9] ? ~win[7:0] : win[7:0];
        dec_data    = 8'h00;
        dec_data[0] = q_word[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = win[8] ? (q_word[i] ^ q_word[i-1])
                                 : ~(q_word[i] ^ q_word[i-1]);
        end
    end

    assign offset_next = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;

    // Alignment FSM. In SEARCH, a full token run wins over the dwell expiry
    // that falls on the same cycle. In LOCKED, the offset is frozen until
    // tokens stop arriving.
    always_comb begin
        state_d         = state_q;
        run_cnt_d       = run_cnt_q;
        dwell_cnt_d     = dwell_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        bit_offset_d    = bit_offset_q;
        realign_count_d = realign_count_q;
        case (state_q)
            SEARCH: begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
                run_cnt_d   = is_token ? run_cnt_q + 1'b1 : '0;
                if (is_token && (run_cnt_q == RUN_W'(CTRL_RUN - 1))) begin
                    state_d   = LOCKED;
                    gap_cnt_d = '0;
                end else if (dwell_cnt_q == DWELL_W'(SEARCH_DWELL - 1)) begin
                    bit_offset_d = offset_next;
                    dwell_cnt_d  = '0;
                    run_cnt_d    = '0;
                end
            end
            LOCKED: begin
                if (is_token) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_W'(LOCK_TIMEOUT - 1)) begin
                    state_d      = SEARCH;
                    bit_offset_d = offset_next;
                    dwell_cnt_d  = '0;
                    run_cnt_d    = '0;
                    gap_cnt_d    = '0;
                    if (realign_count_q != 8'hFF) begin
                        realign_count_d = realign_count_q + 8'd1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Output register. de follows the next state so that it drops together
    // with locked on a timeout.
    always_comb begin
        data_out_d = data_out_q;
        ctrl_out_d = ctrl_out_q;
        de_d       = 1'b0;
        if (is_token) begin
            ctrl_out_d = token_code;
        end else begin
            data_out_d = dec_data;
            de_d       = (state_d == LOCKED);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            state_q         <= SEARCH;
            raw_q           <= '0;
            run_cnt_q       <= '0;
            dwell_cnt_q     <= '0;
            gap_cnt_q       <= '0;
            bit_offset_q    <= '0;
            realign_count_q <= '0;
            data_out_q      <= '0;
            ctrl_out_q      <= '0;
            de_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            raw_q           <= raw_in;
            run_cnt_q       <= run_cnt_d;
            dwell_cnt_q     <= dwell_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            bit_offset_q    <= bit_offset_d;
            realign_count_q <= realign_count_d;
            data_out_q      <= data_out_d;
            ctrl_out_q      <= ctrl_out_d;
            de_q            <= de_d;
        end
    end

    assign data_out      = data_out_q;
    assign ctrl_out      = ctrl_out_q;
    assign de            = de_q;
    assign locked        = (state_q == LOCKED);
    assign bit_offset    = bit_offset_q;
    assign realign_count = realign_count_q;

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side decoder for one TMDS channel, the inverse of the per-channel encoder inside the HDMI transmit path. It takes raw, unaligned 10-bit words from a free-running 10:1 deserializer and locates the symbol boundary by hunting for runs of control tokens. Once aligned, it decodes each symbol into 8-bit video data, DE, and the 2 control bits. It sits in the `pixel_clk` domain and supports loopback self-test of the transmitter and a future capture/overlay input path.

## Interface
Parameters:
- `CTRL_RUN`, 8 — consecutive control tokens at the current offset required to declare lock.
- `SEARCH_DWELL`, 2048 — cycles spent at each bit offset before slipping to the next.
- `LOCK_TIMEOUT`, 4096 — cycles without any control token before lock is dropped.

Ports (one clock; reset is synchronous and active-low):
- `pixel_clk` in 1 — pixel clock; all logic on its rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `raw_in` in 10 — deserializer word, sampled every cycle; bit 0 is earliest on the wire.
- `data_out` out 8 — decoded video byte.
- `ctrl_out` out 2 — {C1,C0} of the most recent control token.
- `de` out 1 — data enable; high only when locked and the current symbol is not a control token.
- `locked` out 1 — alignment achieved.
- `bit_offset` out 4 — current window offset, 0..9.
- `realign_count` out 8 — number of lock losses, saturating at 255.

## Operation
- `raw_q` holds the previous `raw_in`. The concatenation is cat[19:0] = {raw_in, raw_q}, and the aligned window is win = cat[bit_offset +: 10].
- Control tokens are compared as win[9:0]:
  - 1101010100 → 00
  - 0010101011 → 01
  - 0101010100 → 10
  - 1010101011 → 11
- Data decode for non-token windows:
  - If win[9]=1, invert win[7:0] into q; otherwise q = win[7:0].
  - d[0] = q[0].
  - For i = 1..7: d[i] = q[i]^q[i-1] when win[8]=1, else ~(q[i]^q[i-1]).
- Output register updates every cycle:
  - Token: `de` = 0, `ctrl_out` = token code, `data_out` holds its value.
  - Non-token: `de` = `locked_next`, `data_out` = d, `ctrl_out` holds its value.
- The FSM has two states, SEARCH (reset state) and LOCKED.
- SEARCH:
  - `run_cnt` increments on a token and clears on a non-token.
  - `dwell_cnt` increments every cycle.
  - When a token brings `run_cnt` to `CTRL_RUN`: go to LOCKED and clear `gap_cnt`.
  - Otherwise, when `dwell_cnt` reaches `SEARCH_DWELL`-1: advance `bit_offset` (9 wraps to 0), and clear `dwell_cnt` and `run_cnt`.
  - If both happen on the same cycle, lock wins and the offset is unchanged.
- LOCKED:
  - `gap_cnt` clears on a token and otherwise increments.
  - When `gap_cnt` reaches `LOCK_TIMEOUT`-1 with no token that cycle: go to SEARCH, advance `bit_offset` (mod 10), increment `realign_count` (saturating), and clear `dwell_cnt` and `run_cnt`.
  - `bit_offset` is frozen while in LOCKED.
- Counter widths must hold the parameter values without overflow; use 12 bits for the defaults.

## Timing
- Reset values: `data_out`=0, `ctrl_out`=0, `de`=0, `locked`=0, `bit_offset`=0, `realign_count`=0, `raw_q`=0, all counters 0, state SEARCH.
- Latency: the window completed by `raw_in` sampled at edge n appears on the outputs after edge n+1.
- `locked` rises together with the `ctrl_out` of the `CTRL_RUN`-th consecutive token. The first non-token after that has `de`=1.
- Loss of lock: `locked` and `de` fall on the same edge that `bit_offset` changes.
- A new `bit_offset` takes effect on the window formed in the next cycle.
- Reset asserted mid-operation: on the next edge, all state returns to its reset values regardless of FSM state. `raw_q` also clears.
- Worst-case lock time from reset is 10·`SEARCH_DWELL` + `CTRL_RUN` + 1 cycles.

## Test plan
- Aligned stream: 16 × token 1101010100, then 10'h1FF, 10'h100. Expect `locked`=1 at the 8th token output, `ctrl_out`=00, then `data_out`=01/`de`=1, then `data_out`=00/`de`=1.
- Misaligned stream, bit shift of 7: a repeating 1650-cycle line with 370 tokens of code 11 and the rest data. Expect the block to step offsets 0..6 at 2048-cycle intervals, then `locked`=1 with `bit_offset`=7 and correct `ctrl_out`=11.
- Loss of lock: after lock, drive 4096 non-token words. Expect `locked`=0 and `bit_offset` advanced by 1 exactly 4096 cycles after the last token, with `realign_count`=1.
- Wrap: a stream aligned at offset 9 drifts to offset 0 with no tokens. Expect `bit_offset` 9→0 after the dwell, then relock at 0.
- Simultaneous event: the 8th token arrives on the cycle `dwell_cnt`=2047. Expect lock with `bit_offset` unchanged.
- Reset mid-search: assert `rst`=0 for 1 cycle during SEARCH at offset 4. Expect all outputs 0 on the next edge and `bit_offset`=0.
